// File: rtl/dvs_event_mapper_fifo.sv
// dvs_event_mapper_fifo
// Front end of the voxel-binning path. Raw DVS events (unsigned sensor
// coordinates) are range-checked, downsampled onto a 16x16 signed grid
// (-8..+7) in a registered stage, then buffered in a show-ahead FIFO.
// The FIFO lets the binning stage stall without losing events.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid             raw event strobe (cannot be back-pressured)
//   in_x, in_y           raw 8-bit sensor coordinates
//   in_polarity          raw polarity
//   event_valid          FIFO head holds a mapped event
//   event_x, event_y     signed 5-bit grid coordinates of the head event
//   event_polarity       polarity of the head event
//   event_ready          downstream accepts the head event
//   fifo_level           current FIFO occupancy
//   drop_count           events lost to a full FIFO (saturating)
//   reject_count         events rejected as out of range (saturating)
//   overflow             sticky flag, set on the first drop
//
// Handshake: a transfer happens on a clock edge where event_valid and
// event_ready are both high. event_valid is a pure function of the FIFO
// level and never depends on event_ready; while event_valid is high and
// event_ready is low the head outputs stay stable.
module dvs_event_mapper_fifo #(
  parameter int SENSOR_RES = 128,
  parameter int GRID_SIZE  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int COUNT_BITS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_x,
  input  logic [7:0]                    in_y,
  input  logic                          in_polarity,
  output logic                          event_valid,
  output logic [4:0]                    event_x,
  output logic [4:0]                    event_y,
  output logic                          event_polarity,
  input  logic                          event_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [COUNT_BITS-1:0]         drop_count,
  output logic [COUNT_BITS-1:0]         reject_count,
  output logic                          overflow
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int SHIFT = $clog2(SENSOR_RES / GRID_SIZE);
  localparam logic [8:0]    RES9     = 9'(SENSOR_RES);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  // ---------------- stage 1: range check and mapping ----------------
  logic       in_range;
  logic [3:0] cell_x, cell_y;
  logic [4:0] map_x, map_y;

  assign in_range = ({1'b0, in_x} < RES9) && ({1'b0, in_y} < RES9);
  assign cell_x   = 4'(in_x >> SHIFT);
  assign cell_y   = 4'(in_y >> SHIFT);
  // cell - 8 in 5-bit two's complement: the upper half (cell >= 8) maps to
  // 0..7 and the lower half maps to -8..-1, so the top two bits are just
  // the inverted cell MSB.
  assign map_x    = {~cell_x[3], ~cell_x[3], cell_x[2:0]};
  assign map_y    = {~cell_y[3], ~cell_y[3], cell_y[2:0]};

  logic        s1_valid;
  logic [10:0] s1_data;   // {x[4:0], y[4:0], pol}

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_data      <= '0;
      reject_count <= '0;
    end else begin
      s1_valid <= in_valid && in_range;
      if (in_valid && in_range) begin
        s1_data <= {map_x, map_y, in_polarity};
      end
      if (in_valid && !in_range && (reject_count != '1)) begin
        reject_count <= reject_count + COUNT_BITS'(1);
      end
    end
  end

  // ---------------- stage 2: FIFO ----------------
  logic [10:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, rd_en, wr_en, drop;

  assign full        = (fifo_level == FULL_LVL);
  assign event_valid = (fifo_level != '0);
  assign rd_en       = event_valid && event_ready;
  // A full FIFO still takes the write when the head leaves on the same edge.
  assign wr_en       = s1_valid && (!full || rd_en);
  assign drop        = s1_valid && full && !rd_en;

  // Storage has no reset; the head outputs are gated to 0 while empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= s1_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + COUNT_BITS'(1);
      end
    end
  end

  logic [10:0] head;
  assign head           = event_valid ? mem[rd_ptr] : '0;
  assign event_x        = head[10:6];
  assign event_y        = head[5:1];
  assign event_polarity = head[0];

endmodule

// File: tb/tb_dvs_event_mapper_fifo.sv
// Self-checking bench for dvs_event_mapper_fifo. A queue-based model of
// the mapper and FIFO is updated on each clock edge; a compare process
// checks every DUT output against it on each falling edge. Directed
// scenarios add literal expectations for mapping corners, latency, stall
// absorption, overflow, full-with-read and asynchronous reset.
module tb_dvs_event_mapper_fifo;

  localparam int FD   = 16;
  localparam int RES  = 128;
  localparam int CMAX = 65535;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_x = '0;
  logic [7:0]  in_y = '0;
  logic        in_polarity = 1'b0;
  logic        event_valid;
  logic [4:0]  event_x, event_y;
  logic        event_polarity;
  logic        event_ready = 1'b0;
  logic [4:0]  fifo_level;
  logic [15:0] drop_count, reject_count;
  logic        overflow;

  dvs_event_mapper_fifo #(
    .SENSOR_RES(128), .GRID_SIZE(16), .FIFO_DEPTH(FD), .COUNT_BITS(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_polarity(in_polarity),
    .event_valid(event_valid), .event_x(event_x), .event_y(event_y),
    .event_polarity(event_polarity), .event_ready(event_ready),
    .fifo_level(fifo_level), .drop_count(drop_count),
    .reject_count(reject_count), .overflow(overflow)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int x; int y; int p; } ev_t;
  ev_t mq[$];
  ev_t ms1;
  bit  ms1_v;
  int  m_drop, m_rej, m_sz;
  bit  m_ovf, m_rd;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      ms1_v  = 0;
      m_drop = 0;
      m_rej  = 0;
      m_ovf  = 0;
    end else begin
      m_sz = mq.size();
      m_rd = (m_sz != 0) && (event_ready === 1'b1);
      if (m_rd) void'(mq.pop_front());
      if (ms1_v) begin
        if (m_sz < FD || m_rd) mq.push_back(ms1);
        else begin
          if (m_drop < CMAX) m_drop++;
          m_ovf = 1;
        end
      end
      ms1_v = 0;
      if (in_valid) begin
        if (int'(in_x) < RES && int'(in_y) < RES) begin
          ms1_v = 1;
          ms1.x = int'(in_x) / (RES / 16) - 8;
          ms1.y = int'(in_y) / (RES / 16) - 8;
          ms1.p = int'(in_polarity);
        end else if (m_rej < CMAX) begin
          m_rej++;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("event_valid", int'(event_valid), int'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("event_x", int'($signed(event_x)), mq[0].x);
        chk("event_y", int'($signed(event_y)), mq[0].y);
        chk("event_polarity", int'(event_polarity), mq[0].p);
      end else begin
        chk("event_x_empty", int'(event_x), 0);
        chk("event_y_empty", int'(event_y), 0);
        chk("event_pol_empty", int'(event_polarity), 0);
      end
      chk("fifo_level", int'(fifo_level), mq.size());
      chk("drop_count", int'(drop_count), m_drop);
      chk("reject_count", int'(reject_count), m_rej);
      chk("overflow", int'(overflow), int'(m_ovf));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_rand(input bit v);
    in_valid    = v;
    in_x        = 8'($urandom_range(0, RES - 1));
    in_y        = 8'($urandom_range(0, RES - 1));
    in_polarity = 1'($urandom_range(0, 1));
  endtask

  // One event into an empty FIFO with event_ready high: not visible after
  // its sampling edge, visible with the mapped values one edge later.
  task automatic corner(input int x, input int y, input int p,
                        input int ex, input int ey, input string nm);
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'(x); in_y = 8'(y); in_polarity = 1'(p);
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_valid_edge1"}, int'(event_valid), 0);
    @(negedge clk);
    chk({nm, "_valid_edge2"}, int'(event_valid), 1);
    chk({nm, "_x"}, int'($signed(event_x)), ex);
    chk({nm, "_y"}, int'($signed(event_y)), ey);
    chk({nm, "_pol"}, int'(event_polarity), p);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(event_valid), 0);
    chk("rst_level", int'(fifo_level), 0);
    chk("rst_drop", int'(drop_count), 0);
    chk("rst_reject", int'(reject_count), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_x", int'(event_x), 0);

    // mapping corners
    event_ready = 1'b1;
    corner(0,   0,   1, -8, -8, "c00");
    corner(7,   8,   0, -8, -7, "c78");
    corner(127, 127, 1,  7,  7, "c127");
    corner(64,  63,  0,  0, -1, "c6463");

    // out of range
    @(negedge clk);
    in_valid = 1'b1; in_x = 8'd128; in_y = 8'd5;
    @(negedge clk);
    in_x = 8'd5; in_y = 8'd200;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("oor_no_valid", int'(event_valid), 0);
    end
    chk("oor_reject", int'(reject_count), 2);
    chk("oor_drop", int'(drop_count), 0);

    // stall absorb: 16 events spaced by 10 cycles during a 256-cycle stall
    event_ready = 1'b0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      drive_rand((i % 10 == 0) && (i < 160));
    end
    in_valid = 1'b0;
    chk("stall_level", int'(fifo_level), 16);
    chk("stall_drop", int'(drop_count), 0);
    event_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("stall_drain_level", int'(fifo_level), 16 - k);
    end

    // overflow: 20 back-to-back events while stalled
    do_reset();
    event_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive_rand(1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    idle(2);
    chk("ovf_level", int'(fifo_level), 16);
    chk("ovf_drop", int'(drop_count), 4);
    chk("ovf_flag", int'(overflow), 1);
    event_ready = 1'b1;
    idle(18);
    chk("ovf_drained", int'(fifo_level), 0);
    chk("ovf_sticky", int'(overflow), 1);

    // full FIFO with simultaneous read and continuous input
    do_reset();
    event_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive_rand(1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    idle(2);
    chk("full_level", int'(fifo_level), 16);
    drive_rand(1'b1);
    @(negedge clk);
    event_ready = 1'b1;
    drive_rand(1'b1);
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      chk("full_rw_level", int'(fifo_level), 16);
      drive_rand(k < 10);
    end
    @(negedge clk);
    chk("full_rw_level_last", int'(fifo_level), 16);
    idle(20);
    chk("full_rw_drop", int'(drop_count), 0);
    chk("full_rw_empty", int'(fifo_level), 0);

    // asynchronous reset with 5 events buffered
    event_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_rand(1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    idle(2);
    chk("arst_level_before", int'(fifo_level), 5);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", int'(event_valid), 0);
    chk("arst_level", int'(fifo_level), 0);
    chk("arst_x", int'(event_x), 0);
    chk("arst_y", int'(event_y), 0);
    chk("arst_pol", int'(event_polarity), 0);
    chk("arst_drop", int'(drop_count), 0);
    @(negedge clk);
    rst = 1'b0;
    event_ready = 1'b1;
    corner(100, 20, 1, 4, -6, "arst_next");

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      in_valid    = 1'($urandom_range(0, 99) < 70);
      in_x        = 8'($urandom_range(0, 150));
      in_y        = 8'($urandom_range(0, 150));
      in_polarity = 1'($urandom_range(0, 1));
      event_ready = 1'($urandom_range(0, 99) < ((i / 300) % 2 == 0 ? 80 : 30));
    end
    in_valid = 1'b0;
    event_ready = 1'b1;
    idle(20);
    chk("rand_drained", int'(fifo_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
